// File: rtl/sender_queue_pkg.sv
// Shared encodings for the node link queues (sender and receiver sides).
package sender_queue_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [1:0] DEST_RIGHT = 2'b00;
    localparam logic [1:0] DEST_LEFT  = 2'b01;
    localparam logic [1:0] DEST_SELF  = 2'b10;
    localparam logic [1:0] DEST_DROP  = 2'b11;

endpackage

// File: rtl/sender_link.sv
// One transmit link: DEPTH-entry FIFO, gap timer, registered data and one-cycle strobe.
module sender_link
    import sender_queue_pkg::*;
#(
    parameter int unsigned WIDTH = INSTR_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o,
    output logic             check_o,
    output logic             active_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = $clog2(GAP + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             check_q, check_d;

    logic full, empty, pop, do_push;

    // Status flags from the extra pointer MSB; emit only when idle and data is waiting.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && (gap_q == '0);
        // Full is judged on current state, so a same-edge pop never makes room.
        do_push = push_i && !full;
    end

    // Next-state: pointer advance, head capture, strobe and gap reload on emit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        gap_d    = gap_q;
        data_d   = data_q;
        check_d  = 1'b0;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            data_d   = mem_q[rd_ptr_q[AW-1:0]];
            check_d  = 1'b1;
            gap_d    = GW'(GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            check_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            check_q  <= check_d;
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign full_o   = full;
    assign empty_o  = empty;
    assign data_o   = data_q;
    assign check_o  = check_q;
    assign active_o = (gap_q != '0);

endmodule

// File: rtl/sender_queue.sv
// Transmit queue: routes accepted instructions to the right/left/self links or drops them.
module sender_queue
    import sender_queue_pkg::*;
#(
    parameter int unsigned WIDTH = INSTR_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send_valid,
    input  logic [WIDTH-1:0] send_sig,
    input  logic [1:0]       send_dest,
    output logic             send_ready,
    output logic             drop_alert,
    output logic [WIDTH-1:0] out_sig_right,
    output logic [WIDTH-1:0] out_sig_left,
    output logic [WIDTH-1:0] out_sig_self,
    output logic             check_r,
    output logic             check_l,
    output logic             check_s,
    output logic             busy
);

    logic [2:0] full, empty, active, push;
    logic       drop_alert_q, drop_alert_d;

    // Destination decode and ready mux; drops are always accepted.
    always_comb begin
        send_ready = 1'b1;
        unique case (send_dest)
            DEST_RIGHT: send_ready = !full[0];
            DEST_LEFT:  send_ready = !full[1];
            DEST_SELF:  send_ready = !full[2];
            DEST_DROP:  send_ready = 1'b1;
            default:    send_ready = 1'b1;
        endcase
        push[0]      = send_valid && send_ready && (send_dest == DEST_RIGHT);
        push[1]      = send_valid && send_ready && (send_dest == DEST_LEFT);
        push[2]      = send_valid && send_ready && (send_dest == DEST_SELF);
        drop_alert_d = send_valid && (send_dest == DEST_DROP);
        busy         = |(~empty) || |active;
    end

    // One-cycle pulse for each discarded word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_alert_q <= 1'b0;
        end else begin
            drop_alert_q <= drop_alert_d;
        end
    end

    assign drop_alert = drop_alert_q;

    sender_link #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) u_link_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push[0]),
        .data_i   (send_sig),
        .full_o   (full[0]),
        .empty_o  (empty[0]),
        .data_o   (out_sig_right),
        .check_o  (check_r),
        .active_o (active[0])
    );

    sender_link #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) u_link_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push[1]),
        .data_i   (send_sig),
        .full_o   (full[1]),
        .empty_o  (empty[1]),
        .data_o   (out_sig_left),
        .check_o  (check_l),
        .active_o (active[1])
    );

    sender_link #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) u_link_self (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push[2]),
        .data_i   (send_sig),
        .full_o   (full[2]),
        .empty_o  (empty[2]),
        .data_o   (out_sig_self),
        .check_o  (check_s),
        .active_o (active[2])
    );

endmodule

// File: tb/tb_sender_queue.sv
// Scoreboard bench for sender_queue: each accepted word is given its strobe edge from
// the arrival time and the link's previous strobe; a negedge monitor checks every output.
module tb_sender_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             send_valid = 1'b0;
    logic [WIDTH-1:0] send_sig = '0;
    logic [1:0]       send_dest = 2'b00;
    logic             send_ready, drop_alert, check_r, check_l, check_s, busy;
    logic [WIDTH-1:0] out_sig_right, out_sig_left, out_sig_self;

    always #5 clk = ~clk;

    sender_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .send_valid    (send_valid),
        .send_sig      (send_sig),
        .send_dest     (send_dest),
        .send_ready    (send_ready),
        .drop_alert    (drop_alert),
        .out_sig_right (out_sig_right),
        .out_sig_left  (out_sig_left),
        .out_sig_self  (out_sig_self),
        .check_r       (check_r),
        .check_l       (check_l),
        .check_s       (check_s),
        .busy          (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] w;
        int               sched;
    } item_t;

    item_t            lq [3][$];
    int               last_emit [3];
    logic [WIDTH-1:0] last_data [3];
    int               drop_q [$];
    int               edge_n = 0;
    bit               mon_en = 1'b0;
    int               n_pass = 0;
    int               n_total = 0;
    string            lname [3] = '{"right", "left", "self"};

    logic [WIDTH-1:0] osig [3];
    logic [2:0]       strb;
    assign osig[0] = out_sig_right;
    assign osig[1] = out_sig_left;
    assign osig[2] = out_sig_self;
    assign strb    = {check_s, check_l, check_r};

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    // Words still inside link l's FIFO after the most recent edge.
    function automatic int occ(input int l);
        int c = 0;
        for (int i = 0; i < lq[l].size(); i++) if (lq[l][i].sched > edge_n) c++;
        return c;
    endfunction

    task automatic clear_model();
        for (int l = 0; l < 3; l++) begin
            lq[l].delete();
            last_emit[l] = -100;
            last_data[l] = '0;
        end
        drop_q.delete();
    endtask

    // One cycle of upstream activity; returns whether the word was taken at the next edge.
    task automatic drive(input bit v, input logic [WIDTH-1:0] w, input logic [1:0] d,
                         output bit acc);
        bit er;
        int a, s, l;
        @(negedge clk);
        send_valid = v;
        send_sig   = w;
        send_dest  = d;
        #1;
        er = (d == 2'b11) ? 1'b1 : (occ(int'(d)) < DEPTH);
        chk("send_ready", {31'b0, send_ready}, {31'b0, er});
        acc = v && er;
        if (acc) begin
            a = edge_n + 1;
            if (d == 2'b11) begin
                drop_q.push_back(a);
            end else begin
                l = int'(d);
                s = a + 1;
                if (last_emit[l] + GAP + 1 > s) s = last_emit[l] + GAP + 1;
                last_emit[l] = s;
                lq[l].push_back('{w, s});
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic [1:0] d);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 50) begin
            drive(1'b1, w, d, acc);
            n++;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'b00, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        send_valid = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        rst_n = 1'b1;
    endtask

    // Monitor: strobes, held data, drop pulse and busy against the schedule.
    always @(negedge clk) begin
        if (mon_en) begin
            bit es, ed, eb;
            eb = 1'b0;
            for (int l = 0; l < 3; l++) begin
                es = (lq[l].size() > 0) && (lq[l][0].sched == edge_n);
                chk({"check_", lname[l]}, {31'b0, strb[l]}, {31'b0, es});
                if (es) begin
                    last_data[l] = lq[l][0].w;
                    void'(lq[l].pop_front());
                end
                chk({"out_sig_", lname[l]}, osig[l], last_data[l]);
                if (occ(l) > 0 || last_emit[l] + GAP > edge_n) eb = 1'b1;
            end
            ed = (drop_q.size() > 0) && (drop_q[0] == edge_n);
            if (ed) void'(drop_q.pop_front());
            chk("drop_alert", {31'b0, drop_alert}, {31'b0, ed});
            chk("busy", {31'b0, busy}, {31'b0, eb});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit               pending, acc, v;
        logic [WIDTH-1:0] w;
        logic [1:0]       d;

        clear_model();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single word to the right link.
        send(42, 2'b00);
        idle(4);
        // Left then self on consecutive edges.
        send(73, 2'b01);
        send(89, 2'b10);
        idle(4);
        // Back-to-back words spaced by the gap.
        send(1, 2'b00);
        send(2, 2'b00);
        send(3, 2'b00);
        idle(10);
        // Fill the left FIFO behind a running gap; pointers wrap.
        send(490, 2'b01);
        for (int i = 500; i <= 505; i++) send(i, 2'b01);
        idle(30);
        // Discarded word.
        send(800, 2'b11);
        idle(3);
        // Reset after the first of three queued strobes, then latency-1 restart.
        send(10, 2'b00);
        send(11, 2'b00);
        send(12, 2'b00);
        do_reset();
        idle(2);
        send(20, 2'b00);
        idle(5);

        // Random traffic; an un-accepted word is held until taken.
        pending = 1'b0;
        w = '0;
        d = 2'b00;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                w       = $urandom;
                d       = 2'($urandom_range(0, 3));
                pending = 1'b1;
            end
            v = ($urandom_range(0, 3) != 0);
            drive(v, w, d, acc);
            if (acc) pending = 1'b0;
        end
        idle(40);

        for (int l = 0; l < 3; l++) chk({"drained_", lname[l]}, lq[l].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
